ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse over the same ps2_clk/ps2_data pair the mouse receive path uses.
- Runs on the 100 MHz mouse clock. Drives both lines open-drain through low-active output enables; the top level merges these with the inout pads.
- Frame sequence: clock inhibit, request-to-send, 11 device-clocked bits, device acknowledge.

Parameters:
- INHIBIT_CYCLES, 10000, cycles to hold ps2_clk low before request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, maximum cycles between consecutive device falling edges, or waiting for the first edge (15 ms).
- FILTER_LEN, 8, consecutive equal synchronized samples required to accept a new ps2_clk level.

Ports:
- clk  in  1  100 MHz clock
- rst  in  1  asynchronous, active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- tx_done  out  1  one-cycle pulse: byte acknowledged by device
- tx_error  out  1  one-cycle pulse: NACK or timeout
- busy  out  1  high in every state except IDLE
- ps2_clk_in  in  1  raw pad level of ps2_clk
- ps2_data_in  in  1  raw pad level of ps2_data
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release
- ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE
  - ps2_clk_oe=0, ps2_data_oe=0 (lines released immediately, including mid-frame)
  - tx_ready=1 after reset release; tx_done=0, tx_error=0, busy=0
  - bit counter, shift register and timers cleared
- Input conditioning:
  - Both inputs use a 2-flop synchronizer.
  - ps2_clk is additionally filtered by FILTER_LEN.
  - A falling edge (fall) is a filtered 1->0 transition. It is seen 2+FILTER_LEN cycles after the pad edge.
- Handshake:
  - On acceptance, tx_data is latched and odd parity (~^tx_data) is computed.
  - tx_valid outside IDLE is ignored; no queuing.
- FSM:
  - IDLE: tx_ready=1. Accept -> INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES. data_oe=1 asserted on the last cycle (start bit). -> RTS.
  - RTS: clk_oe=0, data_oe=1. Timeout timer runs. First fall -> DATA with bit index 0, data_oe=~tx_data[0].
  - DATA: on each fall present the next bit, LSB first (data_oe=~bit). After the fall that presented bit 7, the next fall presents parity -> PARITY.
  - PARITY: next fall -> data_oe=0 (stop bit) -> STOP.
  - STOP: next fall samples synchronized ps2_data. 0 -> WAIT_IDLE (ack). 1 -> ERROR (NACK).
  - WAIT_IDLE: wait until filtered clk=1 and data=1 -> DONE.
  - DONE: tx_done pulse for 1 cycle -> IDLE.
  - ERROR: both oe=0, tx_error pulse for 1 cycle -> IDLE.
- Output change latency: data_oe changes exactly 1 cycle after fall is detected.
- Timeout:
  - Timer counts in RTS, DATA, PARITY, STOP and WAIT_IDLE; cleared on every fall.
  - Reaching TIMEOUT_CYCLES-1 -> ERROR, with lines released in the same cycle.
- Any fall seen in IDLE or INHIBIT is ignored.
- Every tx_done/tx_error pulse is followed by at least 1 cycle in IDLE before the next accept.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined: NACK or timeout re-enters INHIBIT with the same latched byte, up to 2 retries. tx_error pulses only after the 3rd failure. busy stays high across retries.
- Undefined: the first failure goes straight to ERROR. No retry counter is synthesized.

Decomposition:
- Shared package ps2_pkg:
  - state enum
  - command constants: CMD_RESET 8'hFF, CMD_ENABLE_REPORT 8'hF4, CMD_SET_SAMPLE_RATE 8'hF3, ACK_BYTE 8'hFA
  - default timing constants for 100 MHz
- Sub-module ps2_line_filter: synchronizer, FILTER_LEN debounce and fall detector, instantiated for ps2_clk. The receive path can reuse it.

Test Plan:
- Send 8'hF4; device model clocks at 12.5 kHz and ACKs. Required response:
  - clk_oe low for exactly 10000 cycles
  - bits sampled by the model = 0,0,1,0,1,1,1,1, parity 0, stop 1
  - tx_done pulses once, busy falls the next cycle
- Send 8'hFF: required parity bit 1, then tx_done pulse.
- Device model drives data high at the ack slot: required tx_error pulse, no tx_done, both oe=0. With PS2_HOST_TX_RETRY_EN: 3 INHIBIT phases, then tx_error.
- Device never clocks after RTS: required tx_error exactly TIMEOUT_CYCLES after RTS entry, lines released.
- Assert rst low during DATA bit 4: required clk_oe=0 and data_oe=0 in the same cycle. After release, tx_ready=1 and a new 8'hF3 transfer completes normally.
- Glitch filter: a 3-cycle low pulse on ps2_clk_in during DATA must not advance the bit index. tx_valid held high during busy must cause no second transfer.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, mouse command bytes, 100 MHz timing defaults.
// Latency: n/a (package). Backpressure: n/a.
// Used by both host transmit and receive paths.
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] CMD_RESET           = 8'hFF;
    localparam logic [7:0] CMD_ENABLE_REPORT   = 8'hF4;
    localparam logic [7:0] CMD_SET_SAMPLE_RATE = 8'hF3;
    localparam logic [7:0] ACK_BYTE            = 8'hFA;

    localparam int DEF_INHIBIT_CYCLES = 10000;    // 100 us
    localparam int DEF_TIMEOUT_CYCLES = 1500000;  // 15 ms
    localparam int DEF_FILTER_LEN     = 8;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, FILTER_LEN-sample debounce, registered falling-edge pulse.
// Latency: level/fall update 1+FILTER_LEN edges after the pad change is first sampled.
// Backpressure: none; free-running.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            s1   <= pad;
            s2   <= s1;
            fall <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
                fall  <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11 device-clocked bits, ack check.
// Latency: data_oe changes 1 cycle after a filtered device clock fall; tx_done/tx_error are 1-cycle pulses.
// Backpressure: tx_ready only in IDLE, tx_valid ignored otherwise. Macro PS2_HOST_TX_RETRY_EN adds 2 retries.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        next;
    logic          clk_level;
    logic          clk_fall;
    logic          data_s1;
    logic          data_s;
    logic [7:0]    byte_q;
    logic          par_q;
    logic [2:0]    bit_idx;
    logic [TW-1:0] timer;
    logic          timed;
    logic          tmo_hit;
    logic          fail;
    logic          retry_ok;
    logic          accept;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .pad   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    assign accept  = (state == ST_IDLE) && tx_valid;
    assign timed   = (state inside {ST_RTS, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE});
    // A fall in the same cycle restarts the window rather than expiring it.
    assign tmo_hit = timed && !clk_fall && (timer == TMO_LAST);

`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0] retry_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_cnt <= 2'd0;
        end else if (state == ST_IDLE) begin
            retry_cnt <= 2'd0;
        end else if (fail && retry_ok) begin
            retry_cnt <= retry_cnt + 2'd1;
        end
    end

    assign retry_ok = (retry_cnt != 2'd2);
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_s1 <= 1'b1;
            data_s  <= 1'b1;
            byte_q  <= 8'h00;
            par_q   <= 1'b0;
            bit_idx <= 3'd0;
            timer   <= '0;
        end else begin
            data_s1 <= ps2_data_in;
            data_s  <= data_s1;
            if (accept) begin
                byte_q <= tx_data;
                par_q  <= odd_parity(tx_data);
            end
            if (state == ST_RTS) begin
                bit_idx <= 3'd0;
            end else if (state == ST_DATA && clk_fall) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // One timer serves both the inhibit hold and the inter-edge watchdog.
            if (next != state || (timed && clk_fall)) begin
                timer <= '0;
            end else if (timed || state == ST_INHIBIT) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_comb begin
        next = state;
        fail = 1'b0;
        if (tmo_hit) begin
            fail = 1'b1;
        end else begin
            case (state)
                ST_IDLE:      if (tx_valid) next = ST_INHIBIT;
                ST_INHIBIT:   if (timer == INH_LAST) next = ST_RTS;
                ST_RTS:       if (clk_fall) next = ST_DATA;
                ST_DATA:      if (clk_fall && bit_idx == 3'd7) next = ST_PARITY;
                ST_PARITY:    if (clk_fall) next = ST_STOP;
                ST_STOP: begin
                    if (clk_fall) begin
                        if (data_s) fail = 1'b1;
                        else        next = ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: if (clk_level && data_s) next = ST_DONE;
                ST_DONE:      next = ST_IDLE;
                ST_ERROR:     next = ST_IDLE;
                default:      next = ST_IDLE;
            endcase
        end
        if (fail) begin
            next = retry_ok ? ST_INHIBIT : ST_ERROR;
        end
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_ready    = 1'b0;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        busy        = 1'b1;
        case (state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (timer == INH_LAST);
            end
            ST_RTS:    ps2_data_oe = 1'b1;
            ST_DATA:   ps2_data_oe = ~byte_q[bit_idx];
            ST_PARITY: ps2_data_oe = ~par_q;
            ST_DONE:   tx_done     = 1'b1;
            ST_ERROR:  tx_error    = 1'b1;
            default: begin
                ps2_clk_oe  = 1'b0;
                ps2_data_oe = 1'b0;
            end
        endcase
        // Release the bus in the very cycle the watchdog expires.
        if (tmo_hit) begin
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
        end
    end

endmodule
